bus_addr_arb_mux: RTL and testbench
===================================

Name: bus_addr_arb_mux

Overview:
- Parametrised N-master successor to the 2:1 address/control bus mux.
- Arbitrates round-robin between N master request lines.
- Registers the selected master's address/control word onto the shared bus and holds ownership until the slave signals completion.
- Sits between the masters' address/control outputs and the slave-side address decoder.

Parameters:
- N_CH, 2, number of master channels (2..8).
- DATA_W, 14, width of each address/control word.
- SEL_W, $clog2(N_CH) (min 1), width of the owner index; derived, not overridden.
- TIMEOUT_CYC, 255, ownership cycle limit (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_CH  per-master bus request, level.
- in_bus  in  N_CH*DATA_W  flattened master words; channel k at [k*DATA_W +: DATA_W].
- done  in  1  slave completion pulse for the current transfer.
- grant  out  N_CH  one-hot registered grant; all-zero when idle.
- owner  out  SEL_W  index of the current owner; 0 when idle.
- mux_out  out  DATA_W  registered word of the owning master; zero when idle.
- bus_busy  out  1  high while a master owns the bus.
- timeout  out  1  one-cycle pulse on forced release (tied 0 without the macro).

Behaviour:
- Reset (async, rst=1): state IDLE; grant=0, owner=0, mux_out=0, bus_busy=0, timeout=0; round-robin pointer=0, so channel 0 has highest priority.
- FSM with two states, IDLE and OWN.
- IDLE, any req bit high:
  - Pick the first set req bit starting at the pointer, wrapping modulo N_CH.
  - Next edge: state OWN, grant one-hot for the winner, owner=winner, bus_busy=1, mux_out = that channel's in_bus word.
  - Latency from req to grant/mux_out is 1 cycle.
- IDLE, no req: outputs stay 0. A done pulse in IDLE is ignored.
- OWN:
  - mux_out re-registers the owner's word every cycle (1-cycle delay from in_bus).
  - Other channels' req and in_bus are ignored.
- OWN -> IDLE, next edge, when done=1 or req[owner]=0 (abandon):
  - grant=0, owner=0, mux_out=0, bus_busy=0.
  - Pointer = owner+1 modulo N_CH.
- done and req[owner]=0 together: a single release; no double pointer advance.
- A new request coinciding with release is not granted that cycle.
  - Minimum one IDLE cycle between owners; this is the bus turnaround.
- The pointer advances only on release, never in IDLE.
- req bits for channels >= N_CH do not exist; no X propagation is allowed on unused select codes.
- rst asserted mid-transfer: immediate return to the reset values above. The in-flight transfer is dropped; the slave side must tolerate this.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) clears on entry to OWN and increments each OWN cycle.
  - When it reaches TIMEOUT_CYC without done, release as above and pulse timeout=1 for exactly one cycle, coincident with bus_busy falling.
  - The pointer advances past the offender.
  - done on the same cycle as the limit counts as a normal release: timeout=0.
- Undefined: no counter is built, timeout is tied 0, and ownership is unbounded.

Decomposition:
- Package bus_pkg holds:
  - the state enum (ST_IDLE, ST_OWN);
  - the default DATA_W constant (14);
  - the maximum channel count constant (8).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req, pointer.
  - Outputs: valid, index.
  - Natural to split out so it can be verified standalone.
- The FSM and output registers stay in the top.

Test Plan:
- Reset check: assert rst mid-OWN with grant=2'b01 -> same cycle, grant=0, mux_out=0, bus_busy=0; after release, req=2'b11 -> grant=2'b01 (pointer back to 0).
- Single master: N_CH=2, req=2'b10, in_bus[27:14]=14'h1A5 -> next edge grant=2'b10, owner=1, mux_out=14'h1A5; pulse done -> next edge all outputs 0.
- Fairness: N_CH=4, req=4'b1111 held, done pulsed every 3rd cycle -> grant sequence 0001, 0010, 0100, 1000, 0001, with one idle cycle between each.
- Tracking and isolation: while channel 0 owns the bus, change in_bus ch0 to 14'h3FFF and ch1 to 14'h0001 -> mux_out=14'h3FFF one cycle later; ch1 never appears.
- Abandon and simultaneous events: owner drops req with done=1 in the same cycle -> single release, pointer advances by exactly 1; a new req in the release cycle is granted only after one IDLE cycle.
- BUS_TIMEOUT_EN, TIMEOUT_CYC=4: owner holds the bus with no done -> release after 4 OWN cycles, timeout high for 1 cycle, next requester granted after the turnaround cycle. Rerun without the macro -> ownership persists, timeout stays 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the N-master address/control bus arbiter mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

   // Bus ownership state: idle (turnaround) or owned by one master.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 14;
   localparam int MAX_CH     = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set req bit at or after ptr, wrapping modulo N_CH.
// Latency: combinational.
// Backpressure: none; valid=0 and index=0 when no request is set.
module rr_pick
   import bus_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int SEL_W = 1
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             valid,
   output logic [SEL_W-1:0] index
);

   // Scan from the farthest candidate back towards ptr so the nearest one wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         int c;
         c = int'(ptr) + i;
         if (c >= N_CH) c = c - N_CH;
         if (req[c]) begin
            valid = 1'b1;
            index = SEL_W'(c);
         end
      end
   end

endmodule

// File: rtl/bus_addr_arb_mux.sv
// N-master round-robin arbiter that registers the owner's address/control word onto the shared bus.
// Latency: 1 cycle req->grant/mux_out; one forced IDLE turnaround cycle between owners.
// Backpressure: owner holds the bus until done or req drop; BUS_TIMEOUT_EN adds a forced release after TIMEOUT_CYC cycles.
module bus_addr_arb_mux
   import bus_pkg::*;
#(
   parameter  int N_CH        = 2,
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int TIMEOUT_CYC = 255,
   localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          req,
   input  logic [N_CH*DATA_W-1:0]   in_bus,
   input  logic                     done,
   output logic [N_CH-1:0]          grant,
   output logic [SEL_W-1:0]         owner,
   output logic [DATA_W-1:0]        mux_out,
   output logic                     bus_busy,
   output logic                     timeout
);

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic             pick_vld;
   logic [SEL_W-1:0] pick_idx;
   logic             release_req;
   logic             limit;
   logic [SEL_W-1:0] ptr_next;

   rr_pick #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_vld),
      .index (pick_idx)
   );

   // Completion or abandon by the owner; both together still mean one release.
   assign release_req = done | ~req[owner];
   assign ptr_next    = (owner == SEL_W'(N_CH - 1)) ? '0 : owner + 1'b1;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] own_cnt;
   logic             timeout_r;

   // own_cnt holds completed OWN cycles; this edge closes cycle number own_cnt+1.
   assign limit   = (own_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign timeout = timeout_r;
`else
   assign limit   = 1'b0;
   assign timeout = 1'b0;
`endif

   // Ownership FSM with registered grant, owner, bus word and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         grant    <= '0;
         owner    <= '0;
         mux_out  <= '0;
         bus_busy <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         own_cnt   <= '0;
         timeout_r <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
`ifdef BUS_TIMEOUT_EN
               timeout_r <= 1'b0;
               own_cnt   <= '0;
`endif
               if (pick_vld) begin
                  state    <= ST_OWN;
                  grant    <= N_CH'(1) << pick_idx;
                  owner    <= pick_idx;
                  mux_out  <= in_bus[int'(pick_idx)*DATA_W +: DATA_W];
                  bus_busy <= 1'b1;
               end
            end
            ST_OWN: begin
               if (release_req || limit) begin
                  state    <= ST_IDLE;
                  ptr      <= ptr_next;
                  grant    <= '0;
                  owner    <= '0;
                  mux_out  <= '0;
                  bus_busy <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                  timeout_r <= ~release_req;
`endif
               end else begin
                  mux_out <= in_bus[int'(owner)*DATA_W +: DATA_W];
`ifdef BUS_TIMEOUT_EN
                  own_cnt   <= own_cnt + 1'b1;
                  timeout_r <= 1'b0;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_addr_arb_mux.sv
// Randomized and directed bench for bus_addr_arb_mux against a transaction-level ownership model.
// Latency: model predicts each cycle's registered outputs from the inputs sampled at the edge.
// Backpressure: done, req drops and (with BUS_TIMEOUT_EN) timeouts are all exercised.
module tb_bus_addr_arb_mux;

   localparam int N = 4;
   localparam int W = 14;
   localparam int T = 4;
   localparam int S = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] in_bus;
   logic           done;
   logic [N-1:0]   grant;
   logic [S-1:0]   owner;
   logic [W-1:0]   mux_out;
   logic           bus_busy;
   logic           timeout;

   int errors = 0;
   int checks = 0;

   // Reference model: who owns the bus, since which edge, and where the rotation resumes.
   bit         m_busy;
   int         m_owner;
   int         m_ptr;
   int         m_gedge;
   int         edge_n;
   logic [W-1:0] m_word;
   bit         m_to;

   bus_addr_arb_mux #(
      .N_CH        (N),
      .DATA_W      (W),
      .TIMEOUT_CYC (T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .in_bus   (in_bus),
      .done     (done),
      .grant    (grant),
      .owner    (owner),
      .mux_out  (mux_out),
      .bus_busy (bus_busy),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] word_of(input int k);
      return in_bus[k*W +: W];
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_word  = '0;
      m_to    = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_edge();
      bit rel;
      bit tmo;
      int w;
      m_to = 0;
      if (!m_busy) begin
         w = -1;
         for (int i = 0; i < N; i++)
            if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
         if (w >= 0) begin
            m_busy  = 1;
            m_owner = w;
            m_word  = word_of(w);
            m_gedge = edge_n;
         end
      end else begin
         rel = done || !req[m_owner];
         tmo = 0;
`ifdef BUS_TIMEOUT_EN
         if (!rel && (edge_n - m_gedge) == T) tmo = 1;
`endif
         if (rel || tmo) begin
            m_ptr   = (m_owner + 1) % N;
            m_busy  = 0;
            m_owner = 0;
            m_word  = '0;
            m_to    = tmo;
         end else begin
            m_word = word_of(m_owner);
         end
      end
      edge_n++;
   endtask

   task automatic compare_all(input string tag);
      check_val({tag, ".grant"},    64'(grant),    m_busy ? 64'(1) << m_owner : 64'(0));
      check_val({tag, ".owner"},    64'(owner),    64'(m_owner));
      check_val({tag, ".mux_out"},  64'(mux_out),  64'(m_word));
      check_val({tag, ".bus_busy"}, 64'(bus_busy), 64'(m_busy));
      check_val({tag, ".timeout"},  64'(timeout),  64'(m_to));
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      compare_all(tag);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_word(input int k, input logic [W-1:0] v);
      in_bus[k*W +: W] = v;
   endtask

   logic [N-1:0] seen[$];
   logic [N-1:0] prev_grant;
   logic [N-1:0] fair_exp[5];
   int           to_pulses;

   initial begin
      rst    = 1'b1;
      req    = '0;
      in_bus = '0;
      done   = 1'b0;
      edge_n = 0;
      model_reset();
      @(negedge clk);
      compare_all("reset");
      rst = 1'b0;

      // Idle with a stray done: nothing happens.
      done = 1'b1;
      step("idle_done");
      done = 1'b0;

      // Single master on channel 1.
      req = 4'b0010;
      set_word(1, 14'h1A5);
      step("single");
      check_val("single.grant_const", 64'(grant), 64'h2);
      check_val("single.word_const", 64'(mux_out), 64'h1A5);
      done = 1'b1;
      step("single_rel");
      done = 1'b0;
      req  = '0;
      check_val("single_rel.busy_const", 64'(bus_busy), 64'h0);
      step("single_idle");

      // Fairness: everyone requests, done every third cycle.
      do_reset("fair_rst");
      req = 4'b1111;
      prev_grant = '0;
      for (int i = 0; i < 15; i++) begin
         done = (i % 3 == 2);
         step("fair");
         if (grant != '0 && prev_grant == '0) seen.push_back(grant);
         prev_grant = grant;
      end
      done = 1'b0;
      fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      check_val("fair.count", 64'(seen.size()), 64'd5);
      for (int i = 0; i < 5 && i < seen.size(); i++)
         check_val("fair.order", 64'(seen[i]), 64'(fair_exp[i]));

      // Tracking and isolation, then reset mid-ownership.
      req = '0;
      step("pre_track");
      do_reset("track_rst");
      req = 4'b0011;
      step("track_grant");
      check_val("track.grant_const", 64'(grant), 64'h1);
      set_word(0, 14'h3FFF);
      set_word(1, 14'h0001);
      step("track");
      check_val("track.word_const", 64'(mux_out), 64'h3FFF);
      do_reset("mid_own_rst");
      check_val("mid_own_rst.grant_const", 64'(grant), 64'h0);
      step("post_rst");
      check_val("post_rst.grant_const", 64'(grant), 64'h1);

      // Owner drops req together with done: single release, pointer +1.
      req  = 4'b1110;
      done = 1'b1;
      step("abandon");
      done = 1'b0;
      check_val("abandon.busy_const", 64'(bus_busy), 64'h0);
      step("abandon_next");
      check_val("abandon_next.grant_const", 64'(grant), 64'h2);

      // Hold the bus with no done.
      req = '0;
      step("to_idle");
      do_reset("to_rst");
      req = 4'b0001;
      to_pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step("hold");
         if (timeout) to_pulses++;
      end
`ifdef BUS_TIMEOUT_EN
      check_val("hold.timeout_pulses", 64'(to_pulses), 64'd1);
`else
      check_val("hold.timeout_pulses", 64'(to_pulses), 64'd0);
      check_val("hold.still_owned", 64'(grant), 64'h1);
`endif

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
         done   = ($urandom_range(0, 3) == 0);
         in_bus = (N*W)'({$urandom(), $urandom()});
         step("rand");
         if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
